x_200_operand_loader: RTL and testbench
=======================================

// Module: x_200_operand_loader
// PURPOSE
//  Word-serial deserializer that assembles one 200-bit operand X from a
//  narrow input stream. It presents X with a valid/ready handshake to the
//  combinational x_200_mod_53 reducer that sits directly downstream.
//  Holds X stable until the consumer accepts it, which gives the reducer
//  a full cycle of registered input.
// PARAMETERS
//  X_WIDTH  200  operand width in bits; X is indexed [X_WIDTH:1]
//  WORD_W   32   input word width
//  BEATS    ceil(X_WIDTH/WORD_W) = 7  derived localparam, words per full operand
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  in_data   in   WORD_W   operand word, least-significant word first
//  in_valid  in   1        in_data is valid
//  in_last   in   1        this word is the last of the operand
//  in_ready  out  1        loader accepts a word this cycle
//  X         out  X_WIDTH  assembled operand [X_WIDTH:1], feeds reducer X
//  x_valid   out  1        X holds a complete operand
//  x_ready   in   1        downstream accepts X
//  err_len   out  1        1-cycle pulse: operand exceeded BEATS words
// BEHAVIOUR
//  Reset (async, rst_n=0): state=COLLECT, beat_cnt=0, X=0, x_valid=0,
//   in_ready=0 while rst_n low and 1 from first clk after release, err_len=0.
//  Word accept = in_valid & in_ready. Output accept = x_valid & x_ready.
//  States:
//   COLLECT: in_ready=1. On word accept at beat k (0-based):
//     - X[k*WORD_W+1 +: WORD_W] <= in_data.
//     - Bits above X_WIDTH in beat BEATS-1 are discarded (here the top 24 bits).
//     - k=0 clears all other X bits to 0 in the same cycle, so a short operand
//       is zero-extended.
//     - in_last=1 -> FULL, beat_cnt<=0.
//     - k=BEATS-1 & in_last=0 -> DRAIN, err_len pulses next cycle.
//     - else beat_cnt++.
//   FULL: x_valid=1, in_ready=0, X frozen.
//     - On output accept -> COLLECT. x_valid falls and in_ready rises on the
//       next cycle; there is no same-cycle bypass.
//   DRAIN: in_ready=1, x_valid=0. Accepted words are dropped.
//     - Word accept with in_last=1 -> FULL, presenting the first BEATS words.
//  Latency: x_valid rises exactly 1 cycle after the in_last word is accepted.
//  X changes only in COLLECT. It is stable for the entire x_valid high period.
//  in_valid while in_ready=0 has no effect; the source must hold the word.
//  in_last on beat 0 is legal and gives a single-word operand.
//  err_len: exactly one pulse per overlong operand, regardless of drop count.
//  Reset mid-operand: the partial operand is discarded and no x_valid is
//   produced; the next word after release is treated as beat 0.
//  beat_cnt width: clog2(BEATS). It never exceeds BEATS-1, so there is no
//   wrap-around.
// TESTING
//  1. 7 words {0x35,0,0,0,0,0,0}, last on beat 6 -> X=53; x_valid 1 cycle
//     after beat 6; reducer R=0.
//  2. 1 word 0x6A with in_last -> X=106, upper bits 0; reducer R=0.
//     Then 1 word 0x36 with last -> X=54; R=1, with no stale bits.
//  3. 7 words all 0xFFFFFFFF, last on beat 6 -> X=2^200-1 (top 24 bits of
//     beat 6 dropped); R = (2^200-1) mod 53.
//  4. 9 words, last on the 9th -> err_len high for exactly 1 cycle; X = first
//     7 words; x_valid 1 cycle after the 9th word.
//  5. x_ready held 0 for 5 cycles in FULL, in_valid=1 -> in_ready=0, X and
//     x_valid stable. On release, in_ready=1 the cycle after accept.
//  6. rst_n pulsed low after beat 3 -> outputs clear immediately. The next
//     7-word operand assembles correctly from beat 0.

Source files
------------

// File: rtl/x_200_operand_loader.sv
// rtl/x_200_operand_loader.sv - word-serial loader that assembles a 200-bit operand for the mod-53 reducer
module x_200_operand_loader #(
   parameter int X_WIDTH = 200,
   parameter int WORD_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [X_WIDTH:1]  X,
   output logic              x_valid,
   input  logic              x_ready,
   output logic              err_len
);
   localparam int BEATS  = (X_WIDTH + WORD_W - 1) / WORD_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SH_W   = $clog2(BEATS * WORD_W);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      COLLECT,
      FULL,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [X_WIDTH:1]  x_q, x_d;
   logic              in_ready_q, in_ready_d;
   logic              err_len_q, err_len_d;

   logic              word_acc;
   logic [SH_W-1:0]   shamt;
   logic [X_WIDTH:1]  word_ext;
   logic [X_WIDTH:1]  word_pos;
   logic [X_WIDTH:1]  word_mask;

   assign word_acc = in_valid & in_ready_q;

   // Shifting into an X_WIDTH vector drops the bits of the last beat that lie above X.
   assign shamt     = SH_W'(beat_cnt_q) * SH_W'(WORD_W);
   assign word_ext  = X_WIDTH'(in_data);
   assign word_pos  = word_ext << shamt;
   assign word_mask = X_WIDTH'({WORD_W{1'b1}}) << shamt;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      x_d        = x_q;
      err_len_d  = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (word_acc) begin
               // Beat 0 overwrites everything so a short operand is zero-extended.
               if (beat_cnt_q == '0) begin
                  x_d = word_pos;
               end else begin
                  x_d = (x_q & ~word_mask) | word_pos;
               end
               if (in_last) begin
                  state_d    = FULL;
                  beat_cnt_d = '0;
               end else if (beat_cnt_q == LAST_BEAT) begin
                  state_d    = DRAIN;
                  beat_cnt_d = '0;
                  err_len_d  = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end
         end
         FULL: begin
            if (x_ready) begin
               state_d = COLLECT;
            end
         end
         DRAIN: begin
            if (word_acc && in_last) begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         beat_cnt_q <= '0;
         x_q        <= '0;
         in_ready_q <= 1'b0;
         err_len_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         x_q        <= x_d;
         in_ready_q <= in_ready_d;
         err_len_q  <= err_len_d;
      end
   end

   assign in_ready = in_ready_q;
   assign X        = x_q;
   assign x_valid  = (state_q == FULL);
   assign err_len  = err_len_q;

endmodule

// File: tb/tb_x_200_operand_loader.sv
// tb/tb_x_200_operand_loader.sv - self-checking bench for x_200_operand_loader
module tb_x_200_operand_loader;
   logic          clk;
   logic          rst_n;
   logic [31:0]   in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [200:1]  X;
   logic          x_valid;
   logic          x_ready;
   logic          err_len;

   int pass_cnt;
   int tot_cnt;
   int err_seen;

   typedef struct {
      int                n;
      logic [9:0][31:0]  w;
      logic [199:0]      exp_x;
      int                exp_r;
      int                exp_err;
   } vec_t;

   vec_t tbl [6];

   x_200_operand_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .X        (X),
      .x_valid  (x_valid),
      .x_ready  (x_ready),
      .err_len  (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      if (err_len) err_seen++;
   endtask

   // Reference: the first 7 words laid out LSW first, truncated to 200 bits.
   function automatic logic [199:0] model_x(input int n, input logic [9:0][31:0] w);
      logic [223:0] acc;
      acc = '0;
      for (int i = 0; i < n && i < 7; i++) acc[i*32 +: 32] = w[i];
      return acc[199:0];
   endfunction

   task automatic send_word(input logic [31:0] d, input logic last, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         tick();
      end
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("word_accept_timeout", 200'(in_ready), 200'(1));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_op(input int n, input logic [9:0][31:0] w, input int max_gap);
      err_seen = 0;
      for (int i = 0; i < n; i++) send_word(w[i], (i == n - 1), $urandom_range(0, max_gap));
      chk("latency_x_valid", 200'(x_valid), 200'(1));
   endtask

   task automatic consume(input string nm, input logic [199:0] ex, input int er,
                          input int eerr, input int hold, input bit hold_valid);
      chk({nm, "_x"}, X, ex);
      if (er >= 0) chk({nm, "_r"}, 200'(X % 200'd53), 200'(er));
      chk({nm, "_err_pulses"}, 200'(err_seen), 200'(eerr));
      if (hold_valid) begin
         in_valid = 1'b1;
         in_data  = 32'hDEAD_BEEF;
         in_last  = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({nm, "_hold"}, 200'({in_ready, x_valid, (X == ex)}), 200'(3'b011));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      x_ready  = 1'b1;
      tick();
      x_ready  = 1'b0;
      chk({nm, "_release"}, 200'({in_ready, x_valid}), 200'(2'b10));
   endtask

   initial begin
      logic [9:0][31:0] w;
      int n;
      pass_cnt = 0;
      tot_cnt  = 0;
      err_seen = 0;
      rst_n    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      x_ready  = 1'b0;

      for (int i = 0; i < 6; i++) begin
         tbl[i].w = '0;
         tbl[i].exp_err = 0;
      end
      tbl[0].n = 7; tbl[0].w[0] = 32'h35; tbl[0].exp_x = 200'd53;  tbl[0].exp_r = 0;
      tbl[1].n = 1; tbl[1].w[0] = 32'h6A; tbl[1].exp_x = 200'd106; tbl[1].exp_r = 0;
      tbl[2].n = 1; tbl[2].w[0] = 32'h36; tbl[2].exp_x = 200'd54;  tbl[2].exp_r = 1;
      tbl[3].n = 7; tbl[3].w = {10{32'hFFFF_FFFF}}; tbl[3].exp_x = {200{1'b1}}; tbl[3].exp_r = 46;
      tbl[4].n = 1; tbl[4].w[0] = 32'h36; tbl[4].exp_x = 200'd54;  tbl[4].exp_r = 1;
      tbl[5].n = 9;
      for (int i = 0; i < 9; i++) tbl[5].w[i] = 32'(i + 1);
      tbl[5].exp_x = {8'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
      tbl[5].exp_r = int'(tbl[5].exp_x % 200'd53);
      tbl[5].exp_err = 1;

      repeat (3) @(negedge clk);
      chk("reset_outputs", 200'({in_ready, x_valid, err_len}), 200'(0));
      chk("reset_x", X, 200'd0);
      rst_n = 1'b1;
      tick();
      chk("post_reset_in_ready", 200'({in_ready, x_valid}), 200'(2'b10));

      for (int t = 0; t < 6; t++) begin
         send_op(tbl[t].n, tbl[t].w, 1);
         consume($sformatf("vec%0d", t), tbl[t].exp_x, tbl[t].exp_r, tbl[t].exp_err,
                 (t == 0) ? 5 : 1, (t == 0));
      end

      err_seen = 0;
      for (int i = 0; i < 4; i++) send_word(32'h1111_0000 + 32'(i), 1'b0, 0);
      chk("pre_reset_partial_x", 200'(X != '0), 200'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 200'({in_ready, x_valid, err_len}), 200'(0));
      chk("async_reset_x", X, 200'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rerelease_in_ready", 200'({in_ready, x_valid}), 200'(2'b10));
      for (int i = 0; i < 10; i++) w[i] = $urandom;
      send_op(7, w, 0);
      consume("after_reset", model_x(7, w), -1, 0, 0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(1, 10);
         for (int i = 0; i < 10; i++) w[i] = $urandom;
         send_op(n, w, 2);
         consume($sformatf("rand%0d", k), model_x(n, w), -1, (n > 7) ? 1 : 0,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
